// File: rtl/dsp_wr_capture_pkg.sv
// -----------------------------------------------------------------------------
// dsp_wr_capture_pkg
// Shared definitions for the DSP external write-bus capture path:
//   - default DSP bus widths
//   - FSM state encoding
//   - reset level of the synchronised (active-low) strobes
//   - width of the low-time counter and its compare helper
// -----------------------------------------------------------------------------
package dsp_wr_capture_pkg;

    // Default DSP bus widths
    localparam int DSP_DW = 16;
    localparam int DSP_AW = 8;

    // Low-time counter width; large enough for a minimum low time of 15
    localparam int LCW = 4;

    // Strobes are active low, so a synchroniser that has just come out of
    // reset must present "inactive"
    localparam logic STROBE_RST = 1'b1;

    // Capture FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_QUAL = 2'd2
    } wr_state_t;

    // True when one more active cycle brings the low counter to the
    // required minimum low time
    function automatic logic low_reached(input logic [LCW-1:0] cnt,
                                         input logic [LCW-1:0] min_low);
        return ((cnt + 4'd1) == min_low);
    endfunction

endpackage

// File: rtl/dsp_wr_capture_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser with configurable width and reset value.
// Used both for the DSP strobes and for the address/data buses so that all
// synchronised samples share exactly the same two-cycle delay.
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous active-high reset (both stages load RST_VAL)
//   d    in   W  asynchronous input
//   q    out  W  synchronised output (second stage)
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    // Two-stage shift towards the destination clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/dsp_wr_capture.sv
// -----------------------------------------------------------------------------
// dsp_wr_capture
// Receive side of the DSP external write bus. The asynchronous chip select,
// write strobe, address and data are synchronised into clk_sys. A write is
// accepted once the combined strobe (xzcs low and xwe low) has been seen for
// at least MIN_LOW synchronised cycles; when the strobe then ends, a single
// cycle wr_pulse is issued together with the address/data sampled in the last
// active cycle. Shorter strobes are counted as glitches.
// Ports:
//   clk_sys     in   system clock
//   rst         in   asynchronous active-high reset
//   clken       in   capture enable; low forces IDLE and suppresses pulses
//   xzcs        in   DSP chip select, active low, asynchronous
//   xwe         in   DSP write strobe, active low, asynchronous
//   xaddr       in   AW  DSP address bus, asynchronous
//   xdata       in   DW  DSP data bus, asynchronous
//   wr_pulse    out  one-cycle write strobe, active high
//   wr_addr     out  AW  captured address, held until the next wr_pulse
//   wr_data     out  DW  captured data, held until the next wr_pulse
//   glitch_cnt  out  GCW saturating count of rejected strobes
// -----------------------------------------------------------------------------
module dsp_wr_capture
    import dsp_wr_capture_pkg::*;
#(
    parameter int DW      = DSP_DW,
    parameter int AW      = DSP_AW,
    parameter int MIN_LOW = 2,
    parameter int GCW     = 8
) (
    input  logic           clk_sys,
    input  logic           rst,
    input  logic           clken,
    input  logic           xzcs,
    input  logic           xwe,
    input  logic [AW-1:0]  xaddr,
    input  logic [DW-1:0]  xdata,
    output logic           wr_pulse,
    output logic [AW-1:0]  wr_addr,
    output logic [DW-1:0]  wr_data,
    output logic [GCW-1:0] glitch_cnt
);

    localparam logic [LCW-1:0] MIN_LOW_V = 4'(MIN_LOW);

    logic [1:0]        strb_s2;      // {xzcs, xwe} after two flops
    logic [AW+DW-1:0]  bus_s2;       // {xaddr, xdata} after two flops
    logic [AW-1:0]     addr_s2;
    logic [DW-1:0]     data_s2;
    logic              act;          // combined strobe active, aligned with bus_s2

    logic [AW-1:0]     hold_addr_r;
    logic [DW-1:0]     hold_data_r;
    wr_state_t         state_r;
    logic [LCW-1:0]    low_cnt_r;
    logic [1:0]        fill_r;       // tracks the synchroniser refilling after reset
    logic              armed_r;      // an inactive strobe has been seen since reset

    sync2 #(
        .W       (2),
        .RST_VAL ({2{STROBE_RST}})
    ) u_sync_strb (
        .clk (clk_sys),
        .rst (rst),
        .d   ({xzcs, xwe}),
        .q   (strb_s2)
    );

    sync2 #(
        .W       (AW + DW),
        .RST_VAL ({(AW + DW){1'b0}})
    ) u_sync_bus (
        .clk (clk_sys),
        .rst (rst),
        .d   ({xaddr, xdata}),
        .q   (bus_s2)
    );

    assign addr_s2 = bus_s2[AW+DW-1:DW];
    assign data_s2 = bus_s2[DW-1:0];
    assign act     = ~strb_s2[1] & ~strb_s2[0];

    // Keep the most recent bus sample taken while the strobe is active; the
    // last sample before the strobe ends is the one that gets written
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            hold_addr_r <= {AW{1'b0}};
            hold_data_r <= {DW{1'b0}};
        end else if (act) begin
            hold_addr_r <= addr_s2;
            hold_data_r <= data_s2;
        end else begin
            hold_addr_r <= hold_addr_r;
            hold_data_r <= hold_data_r;
        end
    end

    // Arm capture only after an inactive strobe has been observed through a
    // fully refilled synchroniser. The strobe flops reset to "inactive", so
    // without the fill tracking a strobe held low across reset would look
    // like it had just started and its tail would be written.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            fill_r  <= 2'b00;
            armed_r <= 1'b0;
        end else begin
            fill_r <= {fill_r[0], 1'b1};
            if (fill_r[1] && !act) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // Capture FSM with registered pulse, captured bus and glitch counter
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            low_cnt_r  <= {LCW{1'b0}};
            wr_pulse   <= 1'b0;
            wr_addr    <= {AW{1'b0}};
            wr_data    <= {DW{1'b0}};
            glitch_cnt <= {GCW{1'b0}};
        end else if (!clken) begin
            // Disabled: abandon any strobe in progress without pulsing or
            // counting; captured values and the glitch count are held
            state_r   <= ST_IDLE;
            low_cnt_r <= {LCW{1'b0}};
            wr_pulse  <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (act && armed_r) begin
                        low_cnt_r <= 4'd1;
                        state_r   <= (MIN_LOW == 1) ? ST_QUAL : ST_LOW;
                    end else begin
                        low_cnt_r <= {LCW{1'b0}};
                        state_r   <= ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (act) begin
                        low_cnt_r <= low_cnt_r + 4'd1;
                        if (low_reached(low_cnt_r, MIN_LOW_V)) begin
                            state_r <= ST_QUAL;
                        end else begin
                            state_r <= ST_LOW;
                        end
                    end else begin
                        // Strobe ended before reaching the minimum low time
                        state_r   <= ST_IDLE;
                        low_cnt_r <= {LCW{1'b0}};
                        if (glitch_cnt != {GCW{1'b1}}) begin
                            glitch_cnt <= glitch_cnt + {{(GCW-1){1'b0}}, 1'b1};
                        end else begin
                            glitch_cnt <= glitch_cnt;
                        end
                    end
                end
                ST_QUAL: begin
                    if (act) begin
                        state_r <= ST_QUAL;
                    end else begin
                        // Qualified strobe ended: publish the held sample
                        state_r   <= ST_IDLE;
                        low_cnt_r <= {LCW{1'b0}};
                        wr_pulse  <= 1'b1;
                        wr_addr   <= hold_addr_r;
                        wr_data   <= hold_data_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    low_cnt_r <= {LCW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_wr_capture.sv
// -----------------------------------------------------------------------------
// tb_dsp_wr_capture
// Self-checking bench for dsp_wr_capture (MIN_LOW = 2, GCW = 8). Every write
// expected to produce a pulse is pushed to a scoreboard when it is driven; a
// monitor pops and compares on each wr_pulse.
// -----------------------------------------------------------------------------
module tb_dsp_wr_capture;
    import dsp_wr_capture_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int GCW = 8;

    logic           clk_sys = 1'b0;
    logic           rst;
    logic           clken;
    logic           xzcs;
    logic           xwe;
    logic [AW-1:0]  xaddr;
    logic [DW-1:0]  xdata;
    logic           wr_pulse;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [GCW-1:0] glitch_cnt;

    int n_checks   = 0;
    int n_fail     = 0;
    int n_pulses   = 0;
    int n_expected = 0;
    int exp_glitch = 0;

    logic [AW+DW-1:0] sb_q[$];
    logic [AW+DW-1:0] sb_word;
    logic             prev_pulse = 1'b0;

    dsp_wr_capture #(
        .DW      (DW),
        .AW      (AW),
        .MIN_LOW (2),
        .GCW     (GCW)
    ) dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .clken      (clken),
        .xzcs       (xzcs),
        .xwe        (xwe),
        .xaddr      (xaddr),
        .xdata      (xdata),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest pending write
    always @(negedge clk_sys) begin
        if (wr_pulse === 1'b1) begin
            n_pulses++;
            check_val("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
            if (sb_q.size() == 0) begin
                check_val("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                sb_word = sb_q.pop_front();
                check_val("wr_addr", {24'd0, wr_addr}, {24'd0, sb_word[AW+DW-1:DW]});
                check_val("wr_data", {16'd0, wr_data}, {16'd0, sb_word[DW-1:0]});
            end
        end
        prev_pulse = wr_pulse;
    end

    // Drive one strobe: low for low_cycles clock periods, then idle for gap
    task automatic write_strobe(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int low_cycles, input int gap, input bit expect_pulse);
        @(negedge clk_sys);
        xaddr = a;
        xdata = d;
        xzcs  = 1'b0;
        xwe   = 1'b0;
        if (expect_pulse) begin
            sb_q.push_back({a, d});
            n_expected++;
        end
        repeat (low_cycles) @(negedge clk_sys);
        xwe  = 1'b1;
        xzcs = 1'b1;
        repeat (gap) @(negedge clk_sys);
    endtask

    initial begin
        // Reset asserted while a strobe is active
        rst   = 1'b1;
        clken = 1'b1;
        xzcs  = 1'b0;
        xwe   = 1'b0;
        xaddr = 8'h77;
        xdata = 16'h7777;
        repeat (10) @(negedge clk_sys);
        check_val("rst_pulse", {31'd0, wr_pulse}, 32'd0);
        check_val("rst_addr", {24'd0, wr_addr}, 32'd0);
        check_val("rst_data", {16'd0, wr_data}, 32'd0);
        check_val("rst_glitch", {24'd0, glitch_cnt}, 32'd0);
        check_val("rst_state", {30'd0, dut.state_r}, {30'd0, ST_IDLE});
        // Release with the strobe still low; its tail must not be written
        rst = 1'b0;
        repeat (6) @(negedge clk_sys);
        xwe  = 1'b1;
        xzcs = 1'b1;
        repeat (6) @(negedge clk_sys);
        check_val("rst_tail_no_pulse", n_pulses, 32'd0);
        check_val("rst_tail_no_glitch", {24'd0, glitch_cnt}, 32'd0);

        // Single write with latency check relative to the xwe rise
        write_strobe(8'h12, 16'hA5C3, 6, 0, 1'b1);
        @(posedge clk_sys);              // edge k: s1 samples xwe high
        @(posedge clk_sys); #1;          // edge k+1
        check_val("lat_k1", {31'd0, wr_pulse}, 32'd0);
        @(posedge clk_sys); #1;          // edge k+2
        check_val("lat_k2", {31'd0, wr_pulse}, 32'd1);
        @(posedge clk_sys); #1;
        check_val("lat_k3", {31'd0, wr_pulse}, 32'd0);
        repeat (3) @(negedge clk_sys);
        check_val("single_addr_hold", {24'd0, wr_addr}, 32'h12);
        check_val("single_data_hold", {16'd0, wr_data}, 32'hA5C3);

        // One glitch
        write_strobe(8'h99, 16'h9999, 1, 4, 1'b0);
        exp_glitch = 1;
        check_val("glitch_one", {24'd0, glitch_cnt}, exp_glitch);
        check_val("glitch_keeps_data", {16'd0, wr_data}, 32'hA5C3);

        // clken gating: full strobe and a glitch while disabled are ignored
        clken = 1'b0;
        write_strobe(8'h11, 16'h1111, 6, 4, 1'b0);
        write_strobe(8'h11, 16'h1111, 1, 4, 1'b0);
        check_val("gate_data_hold", {16'd0, wr_data}, 32'hA5C3);
        check_val("gate_addr_hold", {24'd0, wr_addr}, 32'h12);
        check_val("gate_glitch_hold", {24'd0, glitch_cnt}, exp_glitch);
        check_val("gate_no_pulse", n_pulses, 32'd1);
        clken = 1'b1;
        write_strobe(8'h22, 16'h2222, 6, 5, 1'b1);
        check_val("gate_reenable_data", {16'd0, wr_data}, 32'h2222);

        // Minimum qualifying low time (exactly MIN_LOW)
        write_strobe(8'h33, 16'h3333, 2, 5, 1'b1);
        check_val("min_low_data", {16'd0, wr_data}, 32'h3333);
        check_val("min_low_no_glitch", {24'd0, glitch_cnt}, exp_glitch);

        // Back-to-back writes
        write_strobe(8'h01, 16'h0001, 4, 2, 1'b1);
        write_strobe(8'h02, 16'h0002, 4, 2, 1'b1);
        write_strobe(8'h03, 16'h0003, 4, 6, 1'b1);
        check_val("b2b_count", n_pulses, n_expected);

        // xzcs ends the strobe while xwe stays low; data changes mid-strobe
        // and again at the instant xzcs rises (that last value is not taken)
        @(negedge clk_sys);
        xaddr = 8'h5A;
        xdata = 16'hBEEF;
        xzcs  = 1'b0;
        xwe   = 1'b0;
        sb_q.push_back({8'h5A, 16'hCAFE});
        n_expected++;
        repeat (3) @(negedge clk_sys);
        xdata = 16'hCAFE;
        repeat (2) @(negedge clk_sys);
        xzcs  = 1'b1;
        xdata = 16'hDEAD;
        repeat (3) @(negedge clk_sys);
        xwe = 1'b1;
        repeat (4) @(negedge clk_sys);
        check_val("zcs_end_data", {16'd0, wr_data}, 32'hCAFE);

        // Glitch counter saturation: 300 glitches in total
        for (int i = 1; i < 254; i++) begin
            write_strobe(8'h44, 16'h4444, 1, 3, 1'b0);
        end
        exp_glitch = 254;
        check_val("glitch_254", {24'd0, glitch_cnt}, exp_glitch);
        for (int i = 254; i < 300; i++) begin
            write_strobe(8'h44, 16'h4444, 1, 3, 1'b0);
        end
        exp_glitch = 255;
        check_val("glitch_sat", {24'd0, glitch_cnt}, exp_glitch);
        check_val("glitch_no_pulse_data", {16'd0, wr_data}, 32'hCAFE);

        repeat (10) @(negedge clk_sys);
        check_val("sb_empty", sb_q.size(), 32'd0);
        check_val("pulse_total", n_pulses, n_expected);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
